raw_rgb_demosaic: RTL
=====================

RAW_RGB_DEMOSAIC -- requirements
Module: raw_rgb_demosaic

Interface
REQ-001 Parameter PIX_W, default 10: raw Bayer pixel width in bits, range 8..16.
REQ-002 Parameter OUT_W, default 8: per-channel output width, at most PIX_W; output is the top OUT_W bits.
REQ-003 Parameter LINE_MAX, default 1280: maximum active pixels per line and depth of the internal line store.
REQ-004 Port VGA_CLK, input, 1: sole clock; all logic on rising edge.
REQ-005 Port RESET_N, input, 1: asynchronous, active-low reset.
REQ-006 Port iDATA, input, PIX_W: raw Bayer pixel.
REQ-007 Port iDVAL, input, 1: pixel valid (line active).
REQ-008 Port iFVAL, input, 1: frame valid.
REQ-009 Port iPATTERN, input, 2: Bayer phase; 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR.
REQ-010 Ports oRed, oGreen, oBlue, output, OUT_W each: demosaiced pixel.
REQ-011 Port oGray, output, OUT_W: luma, present only under RAW_RGB_GRAY_EN.
REQ-012 Port oDVAL, output, 1: output pixel valid.
REQ-013 Port oLINE_ERR, output, 1: one-cycle pulse on line overrun.

Function
REQ-014 Internal x counter increments on each iDVAL=1 cycle and clears on the cycle after iDVAL falls.
REQ-015 Internal y counter increments when iDVAL falls and clears while iFVAL=0.
REQ-016 iPATTERN is latched on the iFVAL rising edge; changes mid-frame have no effect until the next frame.
REQ-017 Each valid pixel is written to the line store at address x; the previous row's pixel at x is read in the same cycle.
REQ-018 The 2x2 window is {prev row x-1, prev row x, cur row x-1, cur row x}; its phase is (x[0], y[0]) XOR latched pattern bits.
REQ-019 R and B are taken directly from their window positions; G is the sum of the two green samples, right-shifted by 1 (PIX_W+1 bit intermediate, no overflow).
REQ-020 Output latency is exactly 2 cycles from the iDVAL=1 input cycle to the corresponding oDVAL=1 cycle.
REQ-021 oDVAL is 0 for pixels at x=0 or y=0 (incomplete window); colour outputs hold their last value when oDVAL=0.
REQ-022 When x reaches LINE_MAX, further pixels in that line are discarded (no write, no oDVAL) and oLINE_ERR pulses once per affected line.
REQ-023 iFVAL falling mid-line terminates the line: counters clear and the pipeline drains its 2 in-flight pixels normally.
REQ-024 iDVAL gaps within a line (iDVAL=0 for 1 cycle, then 1) are treated as end of line.

Reset
REQ-025 RESET_N=0 asynchronously clears x, y, latched pattern (to 0), pipeline registers, oRed, oGreen, oBlue, oGray and oDVAL to 0, and oLINE_ERR to 0.
REQ-026 Line store contents are not reset; row y=0 never produces output, so stale data is never emitted.
REQ-027 Reset deasserted mid-frame: the block waits for iFVAL low before counting a new frame.

Configuration
REQ-028 Macro RAW_RGB_GRAY_EN defined: oGray = (R + 2G + B) >> 2 on full-precision values, truncated to OUT_W, registered in the same output stage as RGB (no extra latency).
REQ-029 RAW_RGB_GRAY_EN undefined: oGray port and its logic are absent; all other behaviour is identical.

Structure
REQ-030 Package raw_rgb_pkg holds the Bayer pattern encoding constants (RGGB, GRBG, GBRG, BGGR) and the latency constant (2).
REQ-031 Sub-module raw_line_buf: single-clock dual-port line store, LINE_MAX x PIX_W, with 1-cycle read latency, write and read at the same address in one cycle returning old data.

Verification
REQ-032 RGGB, 4x4 frame, pixels R=400, G=200/240, B=100 -> interior outputs oRed=100, oGreen=55, oBlue=25 (8-bit), two cycles after input.
REQ-033 Same frame with iPATTERN=3 (BGGR) -> red and blue swapped: oRed=25, oBlue=100.
REQ-034 Line of LINE_MAX+3 valid pixels -> exactly one oLINE_ERR pulse; no oDVAL for the 3 excess pixels.
REQ-035 iPATTERN toggled mid-frame -> output phase unchanged until the next iFVAL rise.
REQ-036 RESET_N pulsed low mid-line -> all outputs 0 immediately; the first oDVAL occurs only at the second row of the next frame.
REQ-037 RAW_RGB_GRAY_EN defined, R=G=B=1020 (10-bit) -> oGray=255.

Source files
------------

// File: rtl/raw_rgb_pkg.sv
// Shared Bayer demosaic definitions: CFA pattern encoding, pipeline latency and
// the window-phase helper used to locate R/G/B inside the 2x2 window.
package raw_rgb_pkg;

    typedef enum logic [1:0] {
        PAT_RGGB = 2'd0,
        PAT_GRBG = 2'd1,
        PAT_GBRG = 2'd2,
        PAT_BGGR = 2'd3
    } bayer_pat_e;

    // Colour of the newest (bottom-right) pixel of the window, bit0 = column, bit1 = row.
    typedef enum logic [1:0] {
        PH_R  = 2'd0,
        PH_GR = 2'd1,
        PH_GB = 2'd2,
        PH_B  = 2'd3
    } phase_e;

    localparam int DEMOSAIC_LATENCY = 2;

    // Pattern bit0 mirrors columns, bit1 mirrors rows relative to RGGB.
    function automatic phase_e cfa_phase(input logic x0, input logic y0, input logic [1:0] pat);
        return phase_e'({y0 ^ pat[1], x0 ^ pat[0]});
    endfunction

endpackage

// File: rtl/raw_line_buf.sv
// Single-clock dual-port line store, LINE_MAX x PIX_W.
// Latency: 1 cycle read; a same-address write/read returns the old word. No backpressure.
// Backpressure: none, one write and one read per cycle.
module raw_line_buf #(
    parameter int PIX_W    = 10,
    parameter int LINE_MAX = 1280,
    parameter int AW       = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1
) (
    input  logic             core_clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [PIX_W-1:0] wr_dat,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [PIX_W-1:0] rd_dat
);

    logic [PIX_W-1:0] mem_q [LINE_MAX];
    logic [PIX_W-1:0] rd_dat_q;

    // Contents are never reset; the first row of a frame is never emitted.
    always_ff @(posedge core_clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_dat;
        if (rd_en) rd_dat_q <= mem_q[rd_addr];
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/raw_rgb_demosaic.sv
// Bayer RAW to RGB demosaic over a 2x2 window (optional luma under RAW_RGB_GRAY_EN).
// Latency: 2 cycles from accepted iDVAL pixel to oDVAL.
// Backpressure: none; streaming video, excess pixels past LINE_MAX are dropped with oLINE_ERR.
module raw_rgb_demosaic
    import raw_rgb_pkg::*;
#(
    parameter int PIX_W    = 10,
    parameter int OUT_W    = 8,
    parameter int LINE_MAX = 1280
) (
    input  logic             VGA_CLK,
    input  logic             RESET_N,
    input  logic [PIX_W-1:0] iDATA,
    input  logic             iDVAL,
    input  logic             iFVAL,
    input  logic [1:0]       iPATTERN,
    output logic [OUT_W-1:0] oRed,
    output logic [OUT_W-1:0] oGreen,
    output logic [OUT_W-1:0] oBlue,
`ifdef RAW_RGB_GRAY_EN
    output logic [OUT_W-1:0] oGray,
`endif
    output logic             oDVAL,
    output logic             oLINE_ERR
);

    localparam int XW = $clog2(LINE_MAX + 1);
    localparam int AW = (LINE_MAX > 1) ? $clog2(LINE_MAX) : 1;
    localparam int YW = 12;
    localparam logic [XW-1:0] X_LAST = XW'(LINE_MAX);

    logic             fval_q, fval_d;
    logic             frame_q, frame_d;
    bayer_pat_e       pat_q, pat_d;
    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic             dval_q, dval_d;
    logic             err_done_q, err_done_d;
    logic             line_err_q, line_err_d;

    logic             s1_vld_q, s1_vld_d;
    logic [PIX_W-1:0] s1_dat_q, s1_dat_d;
    phase_e           s1_phase_q, s1_phase_d;
    logic             s1_edge_q, s1_edge_d;
    logic [PIX_W-1:0] cp_q, cp_d;
    logic [PIX_W-1:0] pp_q, pp_d;
    logic [PIX_W-1:0] rd_dat;

    logic             o_vld_q, o_vld_d;
    logic [OUT_W-1:0] red_q, red_d;
    logic [OUT_W-1:0] green_q, green_d;
    logic [OUT_W-1:0] blue_q, blue_d;

    logic             fval_rise, frame_on, pix_act, pix_ok;
    logic [1:0]       pat_cur;
    logic [PIX_W-1:0] r_full, b_full, g_full;
    logic [PIX_W:0]   g_sum;

`ifdef RAW_RGB_GRAY_EN
    logic [OUT_W-1:0] gray_q, gray_d;
    logic [PIX_W+1:0] luma_sum;
`endif

    // fval_q resets high so a frame already running at reset release is ignored.
    always_comb begin
        fval_rise = iFVAL && !fval_q;
        frame_on  = iFVAL && (frame_q || fval_rise);
        pat_cur   = fval_rise ? iPATTERN : pat_q;
        pix_act   = iDVAL && frame_on;
        pix_ok    = pix_act && (x_q != X_LAST);

        fval_d     = iFVAL;
        frame_d    = frame_on;
        pat_d      = bayer_pat_e'(pat_cur);
        dval_d     = pix_act;
        err_done_d = pix_act && (err_done_q || !pix_ok);
        line_err_d = pix_act && !pix_ok && !err_done_q;

        x_d = '0;
        if (pix_act) x_d = pix_ok ? x_q + XW'(1) : x_q;

        y_d = y_q;
        if (!iFVAL) begin
            y_d = '0;
        end else if (dval_q && !pix_act) begin
            // Wrap to an even non-zero row so parity and the first-row rule survive overflow.
            y_d = (y_q == '1) ? y_q - YW'(1) : y_q + YW'(1);
        end
    end

    always_comb begin
        s1_vld_d   = pix_ok;
        s1_dat_d   = pix_ok ? iDATA : s1_dat_q;
        s1_phase_d = pix_ok ? cfa_phase(x_q[0], y_q[0], pat_cur) : s1_phase_q;
        s1_edge_d  = pix_ok ? ((x_q == '0) || (y_q == '0)) : s1_edge_q;
        cp_d       = s1_vld_q ? s1_dat_q : cp_q;
        pp_d       = s1_vld_q ? rd_dat : pp_q;
    end

    raw_line_buf #(
        .PIX_W    (PIX_W),
        .LINE_MAX (LINE_MAX),
        .AW       (AW)
    ) u_line_buf (
        .core_clk (VGA_CLK),
        .wr_en    (pix_ok),
        .wr_addr  (x_q[AW-1:0]),
        .wr_dat   (iDATA),
        .rd_en    (pix_ok),
        .rd_addr  (x_q[AW-1:0]),
        .rd_dat   (rd_dat)
    );

    // Window: cp = current row x-1, rd_dat = previous row x, pp = previous row x-1.
    always_comb begin
        r_full = '0;
        b_full = '0;
        g_sum  = '0;
        unique case (s1_phase_q)
            PH_R: begin
                r_full = s1_dat_q;
                b_full = pp_q;
                g_sum  = {1'b0, cp_q} + {1'b0, rd_dat};
            end
            PH_GR: begin
                r_full = cp_q;
                b_full = rd_dat;
                g_sum  = {1'b0, s1_dat_q} + {1'b0, pp_q};
            end
            PH_GB: begin
                r_full = rd_dat;
                b_full = cp_q;
                g_sum  = {1'b0, s1_dat_q} + {1'b0, pp_q};
            end
            PH_B: begin
                r_full = pp_q;
                b_full = s1_dat_q;
                g_sum  = {1'b0, cp_q} + {1'b0, rd_dat};
            end
            default: ;
        endcase
        g_full = g_sum[PIX_W:1];

        o_vld_d = s1_vld_q && !s1_edge_q;
        red_d   = o_vld_d ? r_full[PIX_W-1 -: OUT_W] : red_q;
        green_d = o_vld_d ? g_full[PIX_W-1 -: OUT_W] : green_q;
        blue_d  = o_vld_d ? b_full[PIX_W-1 -: OUT_W] : blue_q;
    end

`ifdef RAW_RGB_GRAY_EN
    always_comb begin
        luma_sum = {2'b00, r_full} + {1'b0, g_full, 1'b0} + {2'b00, b_full};
        gray_d   = o_vld_d ? luma_sum[PIX_W+1 -: OUT_W] : gray_q;
    end
`endif

    always_ff @(posedge VGA_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            fval_q     <= 1'b1;
            frame_q    <= 1'b0;
            pat_q      <= PAT_RGGB;
            x_q        <= '0;
            y_q        <= '0;
            dval_q     <= 1'b0;
            err_done_q <= 1'b0;
            line_err_q <= 1'b0;
            s1_vld_q   <= 1'b0;
            s1_dat_q   <= '0;
            s1_phase_q <= PH_R;
            s1_edge_q  <= 1'b1;
            cp_q       <= '0;
            pp_q       <= '0;
            o_vld_q    <= 1'b0;
            red_q      <= '0;
            green_q    <= '0;
            blue_q     <= '0;
`ifdef RAW_RGB_GRAY_EN
            gray_q     <= '0;
`endif
        end else begin
            fval_q     <= fval_d;
            frame_q    <= frame_d;
            pat_q      <= pat_d;
            x_q        <= x_d;
            y_q        <= y_d;
            dval_q     <= dval_d;
            err_done_q <= err_done_d;
            line_err_q <= line_err_d;
            s1_vld_q   <= s1_vld_d;
            s1_dat_q   <= s1_dat_d;
            s1_phase_q <= s1_phase_d;
            s1_edge_q  <= s1_edge_d;
            cp_q       <= cp_d;
            pp_q       <= pp_d;
            o_vld_q    <= o_vld_d;
            red_q      <= red_d;
            green_q    <= green_d;
            blue_q     <= blue_d;
`ifdef RAW_RGB_GRAY_EN
            gray_q     <= gray_d;
`endif
        end
    end

    assign oRed      = red_q;
    assign oGreen    = green_q;
    assign oBlue     = blue_q;
`ifdef RAW_RGB_GRAY_EN
    assign oGray     = gray_q;
`endif
    assign oDVAL     = o_vld_q;
    assign oLINE_ERR = line_err_q;

endmodule
